// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and helpers for the sobel_stream gradient stage.
//   state_e   : stream FSM states (FILL, RUN, FLUSH)
//   DIR_*     : quantised gradient direction codes (used when SOBEL_DIR_EN is defined)
//   sat_mag   : gradient magnitude per mode, saturated to the output width
//   quant_dir : four-way direction quantisation from gx/gy
package sobel_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] DIR_0   = 2'd0;  // gx dominates
  localparam logic [1:0] DIR_45  = 2'd1;  // diagonal, same signs
  localparam logic [1:0] DIR_90  = 2'd2;  // gy dominates
  localparam logic [1:0] DIR_135 = 2'd3;  // diagonal, opposite signs

  // Helpers work on a wide signed container; callers sign-extend into it.
  localparam int GW = 32;

  function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
    logic [GW-1:0] u;
    u = v;
    return v[GW-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [GW-1:0] sat_mag(input logic signed [GW-1:0] gx,
                                            input logic signed [GW-1:0] gy,
                                            input logic                 mode,
                                            input int                   out_bits);
    logic [GW-1:0] ax, ay, m, lim;
    ax  = abs_val(gx);
    ay  = abs_val(gy);
    m   = mode ? ((ax > ay) ? ax : ay) : ((ax + ay) >> 1);
    lim = (GW'(1) << out_bits) - GW'(1);
    return (m > lim) ? lim : m;
  endfunction

  function automatic logic [1:0] quant_dir(input logic signed [GW-1:0] gx,
                                           input logic signed [GW-1:0] gy);
    logic [GW-1:0] ax, ay;
    ax = abs_val(gx);
    ay = abs_val(gy);
    if (GW'(5) * ay < GW'(2) * ax)      return DIR_0;
    else if (GW'(5) * ax < GW'(2) * ay) return DIR_90;
    else if (gx[GW-1] == gy[GW-1])      return DIR_45;
    else                                return DIR_135;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: circular single-port line store. Each shift writes din_i
// and advances the pointer; dout_o is the sample written DEPTH shifts earlier.
//   clock, reset : clock, asynchronous active-high reset (clears store)
//   shift_en_i   : advance one sample
//   din_i        : sample in
//   dout_o       : sample delayed by DEPTH shifts
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 1280,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          shift_en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q;

  // The slot about to be overwritten holds the oldest sample.
  assign dout_o = mem_q[ptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (shift_en_i) begin
      mem_q[ptr_q] <= din_i;
      ptr_q        <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel gradient stage between two FIFOs.
// Reads a raster frame (WIDTH x HEIGHT), emits exactly WIDTH*HEIGHT magnitudes,
// then zero-pads the last row+1 pixels and rearms for the next frame.
//   clock, reset          : clock, asynchronous active-high reset
//   in_rd_en/in_empty/in_dout     : input FIFO pop interface (data valid while !in_empty)
//   out_wr_en/out_full/out_din    : output FIFO push interface
//   out_dir               : quantised direction, present only with macro SOBEL_DIR_EN
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int PIXEL_BITS = 8,
  parameter int OUT_BITS   = 8,
  parameter int MAG_MODE   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [PIXEL_BITS-1:0] in_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [OUT_BITS-1:0]   out_din
`ifdef SOBEL_DIR_EN
  ,
  output logic [1:0]            out_dir
`endif
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int IW   = $clog2(NPIX);
  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);
  localparam int GXW  = PIXEL_BITS + 4;

  state_e                state_q, state_d;
  logic [IW-1:0]         rd_idx_q, rd_idx_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [PIXEL_BITS-1:0] win_q [3][2];
  logic                  out_valid_q;
  logic [OUT_BITS-1:0]   out_din_q;

  logic step, rd_req, produce, out_ready, border;
  logic [PIXEL_BITS-1:0] sample, lb0_out, lb1_out;
  logic signed [GXW-1:0] p1, p2, p3, p4, p6, p7, p8, p9, gx, gy;
  logic [GW-1:0]         mag_w;

  assign out_ready = !out_valid_q || !out_full;
  assign out_wr_en = out_valid_q && !out_full;
  assign in_rd_en  = rd_req && !reset;
  assign out_din   = out_din_q;
  assign sample    = (state_q == FLUSH) ? '0 : in_dout;

  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    row_d    = row_q;
    col_d    = col_q;
    step     = 1'b0;
    rd_req   = 1'b0;
    unique case (state_q)
      FILL: begin
        step   = !in_empty;
        rd_req = step;
        if (step && rd_idx_q == IW'(WIDTH)) state_d = RUN;
      end
      RUN: begin
        step   = !in_empty && out_ready;
        rd_req = step;
        if (step && rd_idx_q == IW'(NPIX - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        step = out_ready;
        if (step && row_q == RW'(HEIGHT - 1) && col_q == CW'(WIDTH - 1)) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    if (rd_req) rd_idx_d = (rd_idx_q == IW'(NPIX - 1)) ? '0 : rd_idx_q + 1'b1;
    produce = step && (state_q != FILL);
    if (produce) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  sobel_line_buffer #(.DEPTH(WIDTH), .DW(PIXEL_BITS)) u_lb0 (
    .clock(clock), .reset(reset), .shift_en_i(step), .din_i(sample), .dout_o(lb0_out)
  );
  sobel_line_buffer #(.DEPTH(WIDTH), .DW(PIXEL_BITS)) u_lb1 (
    .clock(clock), .reset(reset), .shift_en_i(step), .din_i(lb0_out), .dout_o(lb1_out)
  );

  // The right window column is taken straight from the line buffers and the
  // incoming sample, so the result is ready in the same cycle as its step.
  assign p1 = $signed({4'b0000, win_q[0][0]});
  assign p2 = $signed({4'b0000, win_q[0][1]});
  assign p3 = $signed({4'b0000, lb1_out});
  assign p4 = $signed({4'b0000, win_q[1][0]});
  assign p6 = $signed({4'b0000, lb0_out});
  assign p7 = $signed({4'b0000, win_q[2][0]});
  assign p8 = $signed({4'b0000, win_q[2][1]});
  assign p9 = $signed({4'b0000, sample});

  assign gx = (p3 + (p6 <<< 1) + p9) - (p1 + (p4 <<< 1) + p7);
  assign gy = (p7 + (p8 <<< 1) + p9) - (p1 + (p2 <<< 1) + p3);

  assign mag_w = sat_mag(GW'(gx), GW'(gy), MAG_MODE != 0, OUT_BITS);

  // Border outputs are forced to zero; this also hides the row-wrapped
  // columns that appear in the window at col 0 and col WIDTH-1.
  assign border = (row_q == '0) || (row_q == RW'(HEIGHT - 1)) ||
                  (col_q == '0) || (col_q == CW'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      rd_idx_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_din_q   <= '0;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      if (step) begin
        for (int r = 0; r < 3; r++) win_q[r][0] <= win_q[r][1];
        win_q[0][1] <= lb1_out;
        win_q[1][1] <= lb0_out;
        win_q[2][1] <= sample;
      end
      if (produce) begin
        out_valid_q <= 1'b1;
        out_din_q   <= border ? '0 : OUT_BITS'(mag_w);
      end else if (out_wr_en) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef SOBEL_DIR_EN
  logic [1:0] out_dir_q;
  assign out_dir = out_dir_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        out_dir_q <= DIR_0;
    else if (produce) out_dir_q <= border ? DIR_0 : quant_dir(GW'(gx), GW'(gy));
  end
`endif

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_empty, out_full;
  logic [7:0] in_dout;
  logic       rd0, rd1, wr0, wr1;
  logic [7:0] din0, din1;
`ifdef SOBEL_DIR_EN
  logic [1:0] dir0, dir1;
`endif

  always #5 clock = ~clock;

  sobel_stream #(.WIDTH(W), .HEIGHT(H), .PIXEL_BITS(8), .OUT_BITS(8), .MAG_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .in_rd_en(rd0), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(wr0), .out_full(out_full), .out_din(din0)
`ifdef SOBEL_DIR_EN
    , .out_dir(dir0)
`endif
  );

  sobel_stream #(.WIDTH(W), .HEIGHT(H), .PIXEL_BITS(8), .OUT_BITS(8), .MAG_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .in_rd_en(rd1), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(wr1), .out_full(out_full), .out_din(din1)
`ifdef SOBEL_DIR_EN
    , .out_dir(dir1)
`endif
  );

  int tests = 0;
  int fails = 0;
  int pixq[$];
  int exp0q[$];
  int exp1q[$];
  int expdq[$];
  int img[H][W];
  int got0[N];
  int got1[N];
`ifdef SOBEL_DIR_EN
  int gotd[N];
`endif
  int wcount = 0;
  int rcount = 0;
  bit readahead_chk = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: Sobel on the stored frame with plain integers.
  function automatic void model(input int r, input int c, output int m0, output int m1,
                                output int d);
    int gx, gy, ax, ay;
    m0 = 0; m1 = 0; d = 0;
    if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
      gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
         - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
      gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
         - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      m0 = (ax + ay) / 2;
      if (m0 > 255) m0 = 255;
      m1 = (ax > ay) ? ax : ay;
      if (m1 > 255) m1 = 255;
      if (5 * ay < 2 * ax)                d = 0;
      else if (5 * ax < 2 * ay)           d = 2;
      else if ((gx < 0) == (gy < 0))      d = 1;
      else                                d = 3;
    end
  endfunction

  // kind: 0 constant val, 1 vertical edge, 2 ramp 10*col, 3 diagonal, 4 horizontal edge, 5 random
  task automatic add_frame(input int kind, input int val);
    int m0, m1, d;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       img[r][c] = val;
          1:       img[r][c] = (c < 4) ? 0 : 255;
          2:       img[r][c] = 10 * c;
          3:       img[r][c] = 10 * (r + c);
          4:       img[r][c] = (r < 3) ? 0 : 255;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
        pixq.push_back(img[r][c]);
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        model(r, c, m0, m1, d);
        exp0q.push_back(m0);
        exp1q.push_back(m1);
        expdq.push_back(d);
      end
  endtask

  // One clock: drive FIFO flags at negedge, observe handshakes 1ns later.
  task automatic cycle(input bit stall);
    int e0, e1, ed;
    @(negedge clock);
    in_empty = (pixq.size() == 0) || (stall && ($urandom_range(0, 1) == 1));
    in_dout  = (pixq.size() > 0) ? 8'(pixq[0]) : 8'h00;
    out_full = stall && ($urandom_range(0, 1) == 1);
    #1;
    check("rd_en mode0 vs mode1", int'(rd1), int'(rd0));
    check("wr_en mode0 vs mode1", int'(wr1), int'(wr0));
    if (wr0) begin
      check("write while out_full", int'(out_full), 0);
      check("write with result pending", (exp0q.size() > 0) ? 1 : 0, 1);
      if (exp0q.size() > 0) begin
        e0 = exp0q.pop_front();
        e1 = exp1q.pop_front();
        ed = expdq.pop_front();
        check($sformatf("mag mode0 out#%0d", wcount), int'(din0), e0);
        check($sformatf("mag mode1 out#%0d", wcount), int'(din1), e1);
`ifdef SOBEL_DIR_EN
        check($sformatf("dir mode0 out#%0d", wcount), int'(dir0), ed);
        check($sformatf("dir mode1 out#%0d", wcount), int'(dir1), ed);
        gotd[wcount % N] = int'(dir0);
`endif
        got0[wcount % N] = int'(din0);
        got1[wcount % N] = int'(din1);
        wcount++;
      end
    end
    if (rd0) begin
      check("read while in_empty", int'(in_empty), 0);
      if (readahead_chk)
        check($sformatf("read ahead rd#%0d", rcount), (wcount >= N * (rcount / N)) ? 1 : 0, 1);
      if (!in_empty && pixq.size() > 0) void'(pixq.pop_front());
      rcount++;
    end
  endtask

  task automatic run(input bit stall, input string name);
    int budget;
    budget = 3000;
    while ((pixq.size() > 0 || exp0q.size() > 0) && budget > 0) begin
      cycle(stall);
      budget--;
    end
    check({name, " completes within cycle budget"}, (budget > 0) ? 1 : 0, 1);
    repeat (4) cycle(stall);
  endtask

  initial begin
    int m0, m1, d, target, b;
    reset    = 1'b1;
    in_empty = 1'b1;
    out_full = 1'b0;
    in_dout  = 8'h00;
    repeat (2) @(negedge clock);
    in_empty = 1'b0;
    #1;
    check("reset in_rd_en", int'(rd0), 0);
    check("reset out_wr_en", int'(wr0), 0);
    check("reset out_din", int'(din0), 0);
`ifdef SOBEL_DIR_EN
    check("reset out_dir", int'(dir0), 0);
`endif
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;

    // Two back-to-back constant frames: all zero, no early reads of frame 2.
    add_frame(0, 100);
    add_frame(0, 100);
    run(1'b0, "const100");
    check("const100 total writes", wcount, 2 * N);

    add_frame(1, 0);
    model(1, 3, m0, m1, d);
    check("model vedge (1,3) mode0", m0, 255);
    run(1'b0, "vedge");
    check("vedge (1,3)", got0[1 * W + 3], 255);
    check("vedge (1,4)", got0[1 * W + 4], 255);
    check("vedge (1,2)", got0[1 * W + 2], 0);
    check("vedge (3,5)", got0[3 * W + 5], 0);
    check("vedge (0,3) border", got0[3], 0);
`ifdef SOBEL_DIR_EN
    check("vedge dir (2,3)", gotd[2 * W + 3], 0);
`endif

    add_frame(2, 0);
    model(2, 3, m0, m1, d);
    check("model ramp mode0", m0, 40);
    check("model ramp mode1", m1, 80);
    run(1'b0, "ramp");
    check("ramp mode0 (2,3)", got0[2 * W + 3], 40);
    check("ramp mode1 (2,3)", got1[2 * W + 3], 80);
    check("ramp mode0 (2,7) border", got0[2 * W + 7], 0);
    check("ramp mode1 (5,4) border", got1[5 * W + 4], 0);

    add_frame(3, 0);
    run(1'b0, "diagonal");
`ifdef SOBEL_DIR_EN
    check("diagonal dir (2,3)", gotd[2 * W + 3], 1);
`endif
    add_frame(4, 0);
    run(1'b0, "hedge");
`ifdef SOBEL_DIR_EN
    check("hedge dir (2,3)", gotd[2 * W + 3], 2);
`endif

    // Random FIFO stalls on both sides.
    readahead_chk = 1'b0;
    add_frame(2, 0);
    run(1'b1, "ramp stalled");
    check("ramp stalled mode0 (3,4)", got0[3 * W + 4], 40);
    add_frame(5, 0);
    add_frame(5, 0);
    run(1'b1, "random stalled");
    readahead_chk = 1'b1;
    add_frame(5, 0);
    run(1'b0, "random");

    // Abandon a frame mid-way with reset.
    readahead_chk = 1'b0;
    add_frame(5, 0);
    target = rcount + 20;
    b = 500;
    while (rcount < target && b > 0) begin
      cycle(1'b0);
      b--;
    end
    check("20 reads before reset", (rcount >= target) ? 1 : 0, 1);
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b0;
    out_full = 1'b0;
    #1;
    check("mid-frame reset in_rd_en", int'(rd0), 0);
    check("mid-frame reset out_wr_en", int'(wr0), 0);
    check("mid-frame reset out_din", int'(din0), 0);
    pixq.delete();
    exp0q.delete();
    exp1q.delete();
    expdq.delete();
    wcount = 0;
    rcount = 0;
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;
    readahead_chk = 1'b1;
    add_frame(0, 50);
    run(1'b0, "post-reset const50");
    check("post-reset writes", wcount, N);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Parametrised streaming Sobel gradient stage for the canny pipeline. It sits between the gaussian blur FIFO and the non-max-suppression FIFO.
- Replaces the flat 2*WIDTH+3 shift register with two line buffers plus a 3x3 window.
- Generalises pixel/output widths and frame size, and adds a selectable magnitude mode and full FIFO backpressure.
- Emits exactly WIDTH*HEIGHT results per frame, then rearms for the next frame without reading ahead.

Parameters:
WIDTH, 1280, image columns (>=4)
HEIGHT, 720, image rows (>=3)
PIXEL_BITS, 8, input pixel width (unsigned)
OUT_BITS, 8, output magnitude width (unsigned, saturating)
MAG_MODE, 0, 0 = (|gx|+|gy|)>>1; 1 = max(|gx|,|gy|)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_rd_en  out  1  pop request to input FIFO
in_empty  in  1  input FIFO empty
in_dout  in  PIXEL_BITS  input FIFO data, valid while !in_empty
out_wr_en  out  1  push to output FIFO
out_full  in  1  output FIFO full
out_din  out  OUT_BITS  gradient magnitude
out_dir  out  2  quantised gradient direction (only with SOBEL_DIR_EN)

Behaviour:
- Reset is asynchronous, active-high, on reset; clock is clock. On reset: state=FILL; counters, window and line buffers=0; out_valid=0; in_rd_en=0; out_wr_en=0; out_din=0; out_dir=0.
- Raster pixel index rd_idx runs 0..WIDTH*HEIGHT-1. Output coordinate (row,col) advances one per output step.
- A "step" shifts one sample into the window/line buffers. The sample is in_dout, or 0 as padding in FLUSH.
- out_ready = !out_valid || !out_full.
- FSM:
  - FILL: step when !in_empty; in_rd_en=1; no output. After WIDTH+1 reads go to RUN.
  - RUN: step when !in_empty && out_ready; in_rd_en=1; one result produced. When rd_idx reaches WIDTH*HEIGHT-1 and is consumed, go to FLUSH.
  - FLUSH: step when out_ready; in_rd_en=0; zero padding; one result produced per step. After WIDTH+1 results, go to FILL. The output counters and rd_idx return to 0; line buffers need not be cleared.
- in_rd_en is never asserted in FLUSH, or whenever in_empty=1. Next-frame pixels are not consumed until FILL.
- Output register: a result step loads out_din/out_dir and sets out_valid. out_wr_en = out_valid && !out_full. A write without a new step clears out_valid. A write with a new step keeps out_valid=1.
- Latency: result for (row,col) appears on out_din one cycle after the step that consumed pixel (row+1,col+1), or its padding.
- Window P1..P9 in raster order, centred at (row,col).
  - gx=(P3+2P6+P9)-(P1+2P4+P7)
  - gy=(P7+2P8+P9)-(P1+2P2+P3)
  - gx and gy are signed, PIXEL_BITS+4 bits wide, computed without overflow.
- Border pixels (row 0, row HEIGHT-1, col 0, col WIDTH-1) output 0 and dir 0. Column wrap must never mix pixels of adjacent rows into an interior result.
- Magnitude is computed per MAG_MODE, then saturated to 2^OUT_BITS-1.
- Simultaneous write and stall are handled as above. Reset mid-frame abandons the frame; the next pixel read is treated as pixel 0.

Optional Feature:
- Macro SOBEL_DIR_EN.
- Defined: out_dir port exists. Encoding, on |gx|,|gy|:
  - 0 if 5|gy| < 2|gx|
  - 2 if 5|gx| < 2|gy|
  - else 1 if sign(gx)==sign(gy), 3 otherwise
  - Registered alongside out_din; border = 0.
- Undefined: port and logic absent; magnitude behaviour identical.

Decomposition:
- Package sobel_pkg: state enum {FILL, RUN, FLUSH}; direction encoding constants; function sat_mag(gx,gy,mode).
- Sub-module sobel_line_buffer: parameters DEPTH=WIDTH and DW=PIXEL_BITS. Single-port circular RAM with shift_en; outputs the sample delayed by DEPTH. Two instances are chained.

Test Plan:
- Use WIDTH=8, HEIGHT=6, constant image 100 -> exactly 48 writes, all 0, no reads of the following frame until the 48th write.
- Vertical step edge, cols 0-3 = 0, cols 4-7 = 255, MAG_MODE 0 -> cols 3,4 of interior rows = 255 (saturated from 510); all other outputs 0.
- Horizontal ramp pixel = 10*col, MAG_MODE 0 -> interior = 40; MAG_MODE 1 -> interior = 80; borders 0.
- Random in_empty and out_full (50% each) on the ramp image -> output stream identical to the no-stall run; no write while out_full=1; no read while in_empty=1.
- Reset asserted after 20 reads, then a full constant-50 frame -> 48 zero outputs; no stale data appears.
- SOBEL_DIR_EN, diagonal image pixel = 10*(row+col) -> interior out_dir = 1; vertical edge -> 0; horizontal edge -> 2.
